pc_predict_unit: RTL and testbench
==================================

# pc_predict_unit

Parametrised fetch-stage PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It holds the fetch PC and predicts the next PC every cycle. It accepts branch resolution from EX, raises a flush on misprediction, and redirects fetch to the corrected PC. It also keeps branch and mispredict statistics counters. It replaces the combinational next-PC logic between the fetch PC register and instruction memory.

## Interface
Parameters:
- ADDR_W, 16, PC/address width; instructions are 2-byte aligned, so PC bit 0 is always 0.
- IDX_W, 4, BTB index width; the BTB has 2^IDX_W entries.
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the statistics counters.

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC (hazard or memory stall).
- halt  in  1  hold the PC (HLT in decode); level-sensitive.
- pc  out  ADDR_W  current fetch PC (registered).
- pred_taken  out  1  prediction for the current pc (combinational).
- pred_target  out  ADDR_W  predicted target; equals pc+2 when pred_taken=0.
- ex_valid  in  1  a branch (B or BR) is resolving in EX this cycle.
- ex_pc  in  ADDR_W  PC of the resolving branch.
- ex_taken  in  1  actual branch outcome.
- ex_target  in  ADDR_W  actual taken target (PC+2+(I<<1) or register target).
- ex_pred_taken  in  1  prediction carried down the pipeline with the branch.
- ex_pred_target  in  ADDR_W  predicted target carried with the branch.
- flush  out  1  misprediction; squash the IF/ID and ID/EX contents (combinational).
- branch_cnt  out  CNT_W  number of resolved branches.
- mispred_cnt  out  CNT_W  number of mispredictions.

## Operation
- Index and tag fields:
  - idx = addr[IDX_W:1]
  - tag = addr[ADDR_W-1:IDX_W+1]
- BTB entry contents: valid, tag, target[ADDR_W], ctr[2].
- Lookup (combinational on pc):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : pc+2.
- Mispredict:
  - mis = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
  - flush = mis.
  - Corrected PC = ex_taken ? ex_target : ex_pc+2.
- Next-PC priority, highest first:
  1. mis → corrected PC. A misprediction overrides stall and halt, because the stalled or halted instruction is younger than the branch.
  2. stall | halt → hold pc.
  3. Otherwise → pred_target.
- BTB update, on every edge where ex_valid=1:
  - Hit on ex_pc: ctr increments (saturating at 11) if taken, decrements (saturating at 00) if not taken. When taken, target ← ex_target.
  - Miss and taken: allocate the entry (overwriting any resident entry): valid=1, tag, target=ex_target, ctr=10.
  - Miss and not taken: no change.
- Updates occur regardless of stall and halt.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update contents (read-before-write). The update becomes visible on the next cycle.
- Counters:
  - branch_cnt += 1 on ex_valid.
  - mispred_cnt += 1 on mis.
  - Both wrap modulo 2^CNT_W.
- Arithmetic: all additions are ADDR_W-bit and wrap modulo 2^ADDR_W. For example, pc=16'hFFFE with no prediction gives next pc 16'h0000.

## Timing
- Reset (asynchronous, immediate):
  - pc=RESET_PC.
  - All valid bits = 0 and all ctr = 01 (weakly not-taken).
  - branch_cnt = mispred_cnt = 0.
  - With ex_valid=0, flush=0 and pred_taken=0.
- Reset asserted mid-operation discards any pending redirect. The first edge after rst deasserts fetches from RESET_PC.
- Prediction latency: 0 cycles (same cycle as pc).
- Redirect latency: flush is asserted in the resolving cycle; pc holds the corrected value after that edge.
- A BTB entry allocated at edge N predicts from cycle N+1.
- stall or halt with no misprediction: pc, pred_taken and pred_target are stable across the hold.
- ex_valid is a single-cycle qualifier per branch; the block does not apply backpressure to EX.

## Test plan
- Reset and sequential fetch: rst pulse, no branches → pc = 0000, 0002, 0004; flush=0; counters = 0.
- Cold taken branch:
  - ex_valid with ex_pc=0010, ex_taken=1, ex_target=0040, ex_pred_taken=0 → flush=1, next pc=0040, mispred_cnt=1.
  - pc returning to 0010 later → pred_taken=1, pred_target=0040.
- Counter saturation and decay:
  - Resolve 0010 taken three more times → ctr=11.
  - Resolve not-taken once → ctr=10, prediction still taken.
  - Resolve not-taken again → ctr=01, pred_taken=0.
- Wrong target (BR): predicted taken to 0040, ex_target=0080 → flush=1, pc=0080, BTB target updated to 0080.
- Stall and halt priority:
  - stall=1 for 3 cycles → pc held.
  - Misprediction during stall → pc takes the corrected PC anyway.
  - halt=1 → pc frozen until rst.
- Aliasing and wrap:
  - With IDX_W=4, ex_pc=0010 and 0030 share idx 8; allocating 0030 evicts 0010, so pc=0010 then predicts not-taken.
  - pc=FFFE with no prediction → next pc 0000.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with a direct-mapped BTB of 2-bit saturating predictors.
// Resolves branches from EX, flushes on misprediction and keeps branch statistics.
module pc_predict_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 IDX_W    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              flush,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam int DEPTH = 1 << IDX_W;

  logic              btb_valid  [DEPTH];
  logic [TAG_W-1:0]  btb_tag    [DEPTH];
  logic [ADDR_W-1:0] btb_target [DEPTH];
  logic [1:0]        btb_ctr    [DEPTH];

  logic [IDX_W-1:0]  idx_f;
  logic [IDX_W-1:0]  idx_e;
  logic [TAG_W-1:0]  tag_f;
  logic [TAG_W-1:0]  tag_e;
  logic              hit_f;
  logic              hit_e;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] corrected_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              mis;

  assign idx_f = pc[IDX_W:1];
  assign tag_f = pc[ADDR_W-1:IDX_W+1];
  assign idx_e = ex_pc[IDX_W:1];
  assign tag_e = ex_pc[ADDR_W-1:IDX_W+1];

  // Lookup reads the array before this edge's update lands (read-before-write).
  assign hit_f       = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
  assign hit_e       = btb_valid[idx_e] && (btb_tag[idx_e] == tag_e);
  assign pc_plus2    = pc + ADDR_W'(2);
  assign pred_taken  = hit_f & btb_ctr[idx_f][1];
  assign pred_target = pred_taken ? btb_target[idx_f] : pc_plus2;

  assign mis = ex_valid &
               ((ex_taken != ex_pred_taken) |
                (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign flush        = mis;
  assign corrected_pc = ex_taken ? ex_target : (ex_pc + ADDR_W'(2));

  // The branch in EX is older than anything stalled or halted, so it wins.
  always_comb begin
    next_pc = pred_target;
    if (mis)
      next_pc = corrected_pc;
    else if (stall || halt)
      next_pc = pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (ex_valid) begin
      if (hit_e) begin
        if (ex_taken) begin
          if (btb_ctr[idx_e] != 2'b11)
            btb_ctr[idx_e] <= btb_ctr[idx_e] + 2'd1;
          btb_target[idx_e] <= ex_target;
        end else if (btb_ctr[idx_e] != 2'b00) begin
          btb_ctr[idx_e] <= btb_ctr[idx_e] - 2'd1;
        end
      end else if (ex_taken) begin
        btb_valid[idx_e]  <= 1'b1;
        btb_tag[idx_e]    <= tag_e;
        btb_target[idx_e] <= ex_target;
        btb_ctr[idx_e]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ex_valid)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis)
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios then random traffic, all compared
// against an array-based reference model of the predictor.
module tb_pc_predict_unit;

  localparam int          ADDR_W = 16;
  localparam int          IDX_W  = 4;
  localparam int          CNT_W  = 16;
  localparam int unsigned NE     = 1 << IDX_W;
  localparam int unsigned MASK   = 32'h0000_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              halt = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              ex_valid = 1'b0;
  logic [ADDR_W-1:0] ex_pc = '0;
  logic              ex_taken = 1'b0;
  logic [ADDR_W-1:0] ex_target = '0;
  logic              ex_pred_taken = 1'b0;
  logic [ADDR_W-1:0] ex_pred_target = '0;
  logic              flush;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  pc_predict_unit #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_valid [NE];
  int unsigned m_tagv  [NE];
  int unsigned m_tgt   [NE];
  int unsigned m_ctr   [NE];
  int unsigned m_pc;
  int unsigned m_bcnt;
  int unsigned m_mcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_idx(input int unsigned a);
    return (a / 2) % NE;
  endfunction

  function automatic int unsigned m_tag(input int unsigned a);
    return a / (2 * NE);
  endfunction

  function automatic bit m_hit(input int unsigned a);
    return m_valid[m_idx(a)] && (m_tagv[m_idx(a)] == m_tag(a));
  endfunction

  function automatic bit m_pt(input int unsigned a);
    return m_hit(a) && (m_ctr[m_idx(a)] >= 2);
  endfunction

  function automatic int unsigned m_ptgt(input int unsigned a);
    return m_pt(a) ? m_tgt[m_idx(a)] : ((a + 2) & MASK);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NE); i++) begin
      m_valid[i] = 1'b0;
      m_tagv[i]  = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_pc   = 0;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic set_idle();
    stall = 1'b0; halt = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  // One clock: drive, check combinational outputs mid-cycle, clock, advance the model.
  task automatic cycle(input bit s, input bit h, input bit e, input int unsigned epc,
                       input bit tk, input int unsigned tg, input bit ptk, input int unsigned ptg);
    bit          mis;
    int unsigned npc;
    int unsigned i;
    stall = s; halt = h; ex_valid = e; ex_pc = epc[15:0]; ex_taken = tk;
    ex_target = tg[15:0]; ex_pred_taken = ptk; ex_pred_target = ptg[15:0];
    mis = e && ((tk != ptk) || (tk && ptk && (tg != ptg)));
    #4;
    check_val("pc", 32'(pc), m_pc);
    check_val("pred_taken", 32'(pred_taken), 32'(m_pt(m_pc)));
    check_val("pred_target", 32'(pred_target), m_ptgt(m_pc));
    check_val("flush", 32'(flush), 32'(mis));
    check_val("branch_cnt", 32'(branch_cnt), m_bcnt & MASK);
    check_val("mispred_cnt", 32'(mispred_cnt), m_mcnt & MASK);
    @(posedge clk);
    if (mis) npc = tk ? tg : ((epc + 2) & MASK);
    else if (s || h) npc = m_pc;
    else npc = m_ptgt(m_pc);
    if (e) begin
      i = m_idx(epc);
      if (m_hit(epc)) begin
        if (tk) begin
          if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
          m_tgt[i] = tg;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i] = m_ctr[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tagv[i]  = m_tag(epc);
        m_tgt[i]   = tg;
        m_ctr[i]   = 2;
      end
      m_bcnt++;
    end
    if (mis) m_mcnt++;
    m_pc = npc;
    #1;
    set_idle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Forces fetch to addr through a mispredicted taken branch at 0x0400.
  task automatic redirect(input int unsigned addr);
    cycle(0, 0, 1, 32'h0400, 1, addr, 0, 32'h0402);
  endtask

  task automatic peek(input string tag, input int unsigned epc, input bit ept, input int unsigned etg);
    check_val({tag, "_pc"}, 32'(pc), epc);
    check_val({tag, "_pt"}, 32'(pred_taken), 32'(ept));
    check_val({tag, "_tgt"}, 32'(pred_target), etg);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    #2;
    model_reset();
    check_val("rst_async_pc", 32'(pc), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_flush", 32'(flush), 0);
    check_val("rst_pt", 32'(pred_taken), 0);
    check_val("rst_bcnt", 32'(branch_cnt), 0);
    check_val("rst_mcnt", 32'(mispred_cnt), 0);
  endtask

  initial begin
    int unsigned epc, tg, ptg, sel;
    bit          tk, ptk;

    set_idle();
    #3;
    do_reset();

    idle(3);
    peek("seq", 32'h6, 0, 32'h8);

    cycle(0, 0, 1, 32'h10, 1, 32'h40, 0, 32'h12);
    peek("cold", 32'h40, 0, 32'h42);
    check_val("cold_mcnt", 32'(mispred_cnt), 1);
    redirect(32'h10);
    peek("cold_pred", 32'h10, 1, 32'h40);

    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 32'h10, 1, 32'h40, 1, 32'h40);
    redirect(32'h10);
    peek("sat", 32'h10, 1, 32'h40);
    cycle(0, 0, 1, 32'h10, 0, 32'h40, 1, 32'h40);
    redirect(32'h10);
    peek("decay1", 32'h10, 1, 32'h40);
    cycle(0, 0, 1, 32'h10, 0, 32'h40, 1, 32'h40);
    redirect(32'h10);
    peek("decay2", 32'h10, 0, 32'h12);

    cycle(0, 0, 1, 32'h10, 1, 32'h40, 0, 32'h12);
    cycle(0, 0, 1, 32'h10, 1, 32'h80, 1, 32'h40);
    peek("wrong_tgt", 32'h80, 0, 32'h82);
    redirect(32'h10);
    peek("new_tgt", 32'h10, 1, 32'h80);

    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    peek("stall", 32'h10, 1, 32'h80);
    cycle(1, 0, 1, 32'h10, 0, 32'h80, 1, 32'h80);
    peek("stall_mis", 32'h12, 0, 32'h14);

    cycle(0, 0, 1, 32'h30, 1, 32'h50, 0, 32'h32);
    redirect(32'h10);
    peek("alias", 32'h10, 0, 32'h12);

    redirect(32'hFFFE);
    peek("wrap0", 32'hFFFE, 0, 32'h0000);
    idle(1);
    check_val("wrap_pc", 32'(pc), 0);

    for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check_val("halt_pc", 32'(pc), 0);
    do_reset();
    check_val("halt_rst_pc", 32'(pc), 0);
    idle(2);

    // reset arriving while a redirect is pending wins over the redirect
    redirect(32'h10);
    ex_valid = 1'b1; ex_pc = 16'h0010; ex_taken = 1'b1; ex_target = 16'h0200;
    ex_pred_taken = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_pc", 32'(pc), 0);
    @(posedge clk);
    #1;
    check_val("midrst_hold", 32'(pc), 0);
    set_idle();
    rst = 1'b0;
    model_reset();
    idle(2);

    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: epc = 32'h10;
        1: epc = 32'h30;
        2: epc = 32'hFFFE;
        3: epc = m_pc;
        4: epc = 32'h0400;
        default: epc = $urandom_range(0, 32'hFFFF) & 32'hFFFE;
      endcase
      tk = $urandom_range(0, 1);
      tg = ($urandom_range(0, 3) == 0) ? 32'h10 : ($urandom_range(0, 32'hFFFF) & 32'hFFFE);
      if ($urandom_range(0, 1) == 1) begin
        ptk = m_pt(epc);
        ptg = m_ptgt(epc);
        if (tk && $urandom_range(0, 1) == 1) tg = ptg;
      end else begin
        ptk = $urandom_range(0, 1);
        ptg = $urandom_range(0, 32'hFFFF) & 32'hFFFE;
      end
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0), epc, tk, tg, ptk, ptg);
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
